// File: rtl/sysid_checker_pkg.sv
// ---------------------------------------------------------------------------
// sysid_checker_pkg
//   Shared definitions for the sysid checker: FSM state encoding, default
//   expected ID/timestamp words, bus data width and the width of the
//   optional waitrequest watchdog counter.
// ---------------------------------------------------------------------------
package sysid_checker_pkg;

    localparam int DATA_W = 32;
    localparam int WDOG_W = 16;

    localparam logic [DATA_W-1:0] DEFAULT_ID        = 32'h0000_0000;
    localparam logic [DATA_W-1:0] DEFAULT_TIMESTAMP = 32'd1316073944;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RD_ID  = 2'd1;
    localparam state_t ST_RD_TS  = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

    function automatic logic words_match(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// ---------------------------------------------------------------------------
// sysid_checker_if
//   Avalon-MM read-only link between the checker (master) and the sysid
//   slave.
//     address     : word address (0 = ID, 1 = timestamp)
//     read        : read strobe
//     waitrequest : stall from slave/fabric
//     readdata    : read data, valid when read=1 and waitrequest=0
// ---------------------------------------------------------------------------
interface sysid_checker_if;
    import sysid_checker_pkg::*;

    logic              address;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );

endinterface

// File: rtl/sysid_checker_wdog.sv
// ---------------------------------------------------------------------------
// sysid_checker_wdog
//   Waitrequest watchdog. Counts stall cycles of the current read and flags
//   the stall cycle that brings the count up to LIMIT.
//   Ports:
//     clock  : clock
//     reset  : asynchronous active-high reset
//     clear  : restart the count (no read in progress or a read completed)
//     tick   : one stall cycle of the current read
//     expire : this stall cycle is the LIMIT-th one
// ---------------------------------------------------------------------------
module sysid_checker_wdog
    import sysid_checker_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the stall cycle whose increment makes the count equal LIMIT,
    // so the master can drop read on the following edge.
    assign expire = tick && (cnt == LAST);

endmodule

// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
//   Reads the system ID (word 0) and build timestamp (word 1) from a sysid
//   slave over Avalon-MM and compares them against expected values.
//
//   Parameters:
//     EXPECTED_ID        : expected word at address 0
//     EXPECTED_TIMESTAMP : expected word at address 1
//     TIMEOUT_CYCLES     : stall cycles tolerated per read (1..65535)
//
//   Ports:
//     clock, reset : clock, asynchronous active-high reset
//     start        : one-cycle pulse starting a check sequence
//     bus          : Avalon-MM master side (address, read, waitrequest,
//                    readdata)
//     busy         : sequence in progress
//     done         : one-cycle completion pulse
//     pass         : sticky result, both words matched
//     id_value     : captured word 0
//     ts_value     : captured word 1
//     timeout      : sticky, last sequence aborted on a stall timeout
//
//   Build option: define SYSID_CHECKER_TIMEOUT_EN to enable the waitrequest
//   watchdog. Without it the checker waits indefinitely and timeout is 0.
// ---------------------------------------------------------------------------
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = DEFAULT_ID,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = DEFAULT_TIMESTAMP,
    parameter int                TIMEOUT_CYCLES     = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    sysid_checker_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value,
    output logic              timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sysid_checker: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t state;
    logic   rst_hold;
    logic   start_q;
    logic   launch;
    logic   in_read;
    logic   handshake;
    logic   expire;

    // Reset is applied asynchronously but released through this flop, so
    // the cycle right after deassertion still behaves as reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
        end
    end

    // Start is registered so the FSM leaves IDLE one cycle after the pulse.
    // Only pulses seen in IDLE are taken, which also discards a start that
    // coincides with done (the FSM is still in FINISH then).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start && !rst_hold && !start_q && (state == ST_IDLE);
        end
    end

    assign launch    = start_q;
    assign in_read   = (state == ST_RD_ID) || (state == ST_RD_TS);
    assign handshake = in_read && !bus.waitrequest;

    assign bus.read    = in_read;
    assign bus.address = (state == ST_RD_TS);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_FINISH);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic timeout_q;

    sysid_checker_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_read || handshake),
        .tick   (in_read && bus.waitrequest),
        .expire (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (launch) begin
            timeout_q <= 1'b0;
        end else if (expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            id_value <= '0;
            ts_value <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state    <= ST_RD_ID;
                        id_value <= '0;
                        ts_value <= '0;
                        pass     <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (expire) begin
                        state <= ST_FINISH;
                    end else if (handshake) begin
                        id_value <= bus.readdata;
                        state    <= ST_RD_TS;
                    end
                end
                ST_RD_TS: begin
                    if (expire) begin
                        state <= ST_FINISH;
                    end else if (handshake) begin
                        ts_value <= bus.readdata;
                        // Result is settled on entry to FINISH so it is
                        // already valid alongside the done pulse.
                        pass     <= words_match(id_value, EXPECTED_ID) &&
                                    words_match(bus.readdata, EXPECTED_TIMESTAMP) &&
                                    !timeout;
                        state    <= ST_FINISH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_sysid_checker
//   Directed bench for sysid_checker with an Avalon slave model, an
//   expected-result queue filled by the stimulus and a monitor that checks
//   every done pulse against it.
// ---------------------------------------------------------------------------
module tb_sysid_checker;

    localparam logic [31:0] TS_OK = 32'd1316073944;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        pass;
        logic        tmo;
        int          lat;
        int          run;
        int          start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [31:0] id_value, ts_value;

    logic [31:0] slv_id, slv_ts;
    int          stall_n;
    int          stall_cnt;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_done = 0;
    int          n_push = 0;
    exp_t        sb[$];

    logic        chk_stable = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_addr = 1'b0;
    int          run = 0;
    int          last_run = 0;

    sysid_checker_if bus_if ();

    sysid_checker #(
        .EXPECTED_ID        (32'h0000_0000),
        .EXPECTED_TIMESTAMP (TS_OK),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock    (clk),
        .reset    (rst),
        .start    (start),
        .bus      (bus_if),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .id_value (id_value),
        .ts_value (ts_value),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: stalls each read for stall_n cycles, then returns the word.
    assign bus_if.waitrequest = bus_if.read && (stall_cnt < stall_n);
    assign bus_if.readdata    = bus_if.address ? slv_ts : slv_id;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 0;
        end else if (bus_if.read && bus_if.waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues a start pulse in the current cycle; returns one cycle later.
    task automatic issue(input logic [31:0] w_id, input logic [31:0] w_ts, input int stalls,
                         input logic push, input logic e_pass, input logic e_tmo,
                         input int e_lat, input int e_run, input logic [31:0] e_id,
                         input logic [31:0] e_ts);
        exp_t e;
        slv_id  = w_id;
        slv_ts  = w_ts;
        stall_n = stalls;
        start   = 1'b1;
        if (push) begin
            e.id = e_id; e.ts = e_ts; e.pass = e_pass; e.tmo = e_tmo;
            e.lat = e_lat; e.run = e_run; e.start_cyc = cyc;
            sb.push_back(e);
            n_push++;
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},    bus_if.read, 1'b0);
        check({tag, "_address"}, bus_if.address, 1'b0);
        check({tag, "_busy"},    busy, 1'b0);
        check({tag, "_done"},    done, 1'b0);
        check({tag, "_pass"},    pass, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_id"},      id_value, 32'h0);
        check({tag, "_ts"},      ts_value, 32'h0);
    endtask

    // Monitor: samples on the falling edge, checks stall stability and
    // scores each done pulse against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        int   obs_run;
        if (rst) begin
            run        = 0;
            last_run   = 0;
            prev_stall = 1'b0;
        end else begin
            if (chk_stable && prev_stall) begin
                check("stall_read_hold", bus_if.read, 1'b1);
                check("stall_addr_hold", bus_if.address, prev_addr);
            end
            prev_stall = bus_if.read && bus_if.waitrequest;
            prev_addr  = bus_if.address;
            if (bus_if.read && bus_if.waitrequest) begin
                run++;
            end else if (bus_if.read) begin
                last_run = run;
                run      = 0;
            end
            if (done) begin
                n_done++;
                obs_run = (run != 0) ? run : last_run;
                run = 0;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                    check("done_id",      id_value, e.id);
                    check("done_ts",      ts_value, e.ts);
                    check("done_pass",    pass, e.pass);
                    check("done_timeout", timeout, e.tmo);
                    check("done_read",    bus_if.read, 1'b0);
                    check("last_stall_run", 64'(obs_run), 64'(e.run));
                end
            end
        end
    end

    initial begin
        int budget;
        rst     = 1'b1;
        start   = 1'b0;
        stall_n = 0;
        slv_id  = 32'h0;
        slv_ts  = TS_OK;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Clean reads, matching words.
        issue(32'h0, TS_OK, 0, 1'b1, 1'b1, 1'b0, 4, 0, 32'h0, TS_OK);
        tick(8);

        // Timestamp off by one.
        issue(32'h0, TS_OK + 32'd1, 0, 1'b1, 1'b0, 1'b0, 4, 0, 32'h0, TS_OK + 32'd1);
        tick(8);

        // Three stall cycles per read; results cleared in first RD_ID cycle.
        chk_stable = 1'b1;
        issue(32'h0, TS_OK, 3, 1'b1, 1'b1, 1'b0, 10, 3, 32'h0, TS_OK);
        tick(1);
        check("clear_busy",    busy, 1'b1);
        check("clear_read",    bus_if.read, 1'b1);
        check("clear_address", bus_if.address, 1'b0);
        check("clear_ts",      ts_value, 32'h0);
        check("clear_pass",    pass, 1'b0);
        tick(12);
        chk_stable = 1'b0;

`ifdef SYSID_CHECKER_TIMEOUT_EN
        // Slave never answers: watchdog aborts after 8 stall cycles.
        issue(32'h0, TS_OK, 1000, 1'b1, 1'b0, 1'b1, 10, 8, 32'h0, 32'h0);
        tick(14);
        check("tmo_idle_read", bus_if.read, 1'b0);
        stall_n = 0;
`endif

        // Reset in the second RD_TS stall cycle aborts without done.
        issue(32'h0, TS_OK, 3, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
        tick(6);
        check("pre_reset_read",    bus_if.read, 1'b1);
        check("pre_reset_address", bus_if.address, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("midread_reset");
        tick(2);
        rst = 1'b0;
        tick(2);
        issue(32'h0, TS_OK, 0, 1'b1, 1'b1, 1'b0, 4, 0, 32'h0, TS_OK);
        tick(8);

        // Starts while busy and coincident with done are ignored.
        issue(32'h0, TS_OK, 0, 1'b1, 1'b1, 1'b0, 4, 0, 32'h0, TS_OK);
        tick(1);
        start = 1'b1;
        tick(2);
        check("start_at_done", done, 1'b1);
        tick(1);
        start = 1'b0;
        tick(12);
        check("idle_after_ignored_start", busy, 1'b0);

        budget = 50;
        while (sb.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        check("pending_expected", 64'(sb.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, the system ID value expected at slave word address 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'd1316073944, the timestamp expected at slave word address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of waitrequest cycles tolerated per read (range 1..65535).
REQ-004 SHALL provide clock, input, 1: sole clock; all logic is clocked on its rising edge.
REQ-005 SHALL provide reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL provide start, input, 1: one-cycle pulse that begins a check sequence.
REQ-007 SHALL provide address, output, 1: Avalon-MM word address to the sysid slave.
REQ-008 SHALL provide read, output, 1: Avalon-MM read strobe.
REQ-009 SHALL provide waitrequest, input, 1: Avalon-MM stall from the slave or fabric.
REQ-010 SHALL provide readdata, input, 32: Avalon-MM read data, valid in the cycle where read=1 and waitrequest=0.
REQ-011 SHALL provide busy, output, 1: a sequence is in progress.
REQ-012 SHALL provide done, output, 1: one-cycle pulse when a sequence completes.
REQ-013 SHALL provide pass, output, 1: sticky result, high when both words matched.
REQ-014 SHALL provide id_value, output, 32, and ts_value, output, 32: the captured words.
REQ-015 SHALL provide timeout, output, 1: sticky flag set when the last sequence aborted.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ID, RD_TS and FINISH.
REQ-017 IDLE SHALL go to RD_ID on start=1; start SHALL be ignored in every other state.
REQ-018 RD_ID SHALL drive read=1 and address=0, holding both stable while waitrequest=1.
REQ-019 RD_ID SHALL capture readdata into id_value on read & !waitrequest and then go to RD_TS.
REQ-020 RD_TS SHALL drive read=1 and address=1, holding both stable while waitrequest=1.
REQ-021 RD_TS SHALL capture readdata into ts_value on read & !waitrequest and then go to FINISH.
REQ-022 FINISH SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 In FINISH, pass SHALL be set to (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TIMESTAMP) && !timeout.
REQ-024 Minimum latency SHALL be exactly 4 cycles from the start cycle to the done cycle when waitrequest=0; each waitrequest cycle adds 1.
REQ-025 read SHALL be 0 in IDLE and FINISH; address SHALL be 0 when read=0.
REQ-026 On start, pass, timeout, id_value and ts_value SHALL clear, with the new values visible in the first RD_ID cycle.
REQ-027 busy SHALL be high in RD_ID, RD_TS and FINISH.
REQ-028 A start coincident with done SHALL be ignored.

Reset
REQ-029 Asserting reset at any time, including mid-read, SHALL force state=IDLE, read=0, address=0, busy=0, done=0, pass=0, timeout=0, id_value=0 and ts_value=0, with no completion pulse.
REQ-030 Deassertion of reset SHALL be synchronised internally, and the first start SHALL be accepted one cycle after deassertion.

Configuration
REQ-031 With SYSID_CHECKER_TIMEOUT_EN defined, a 16-bit wait counter SHALL clear on each new read and increment per waitrequest cycle.
REQ-032 With SYSID_CHECKER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL deassert read, set timeout, clear pass and go to FINISH.
REQ-033 With SYSID_CHECKER_TIMEOUT_EN undefined, no counter SHALL exist, the block SHALL wait indefinitely, and timeout SHALL be tied to 0.

Structure
REQ-034 The state encoding typedef, the default ID/timestamp constants and the counter width SHALL be placed in the package sysid_checker_pkg.
REQ-035 The wait counter SHALL be a sub-module, sysid_checker_wdog, instantiated only under SYSID_CHECKER_TIMEOUT_EN.

Verification
REQ-036 Slave with no stalls returning 0 at address 0 and 1316073944 at address 1, start -> done 4 cycles later, pass=1, id_value=0, ts_value=1316073944.
REQ-037 Timestamp returned as 1316073945 -> done pulse, pass=0, ts_value=1316073945, timeout=0.
REQ-038 waitrequest held 3 cycles on each read -> read and address stable throughout, done 10 cycles after start, pass=1.
REQ-039 (TIMEOUT_EN, TIMEOUT_CYCLES=8) waitrequest stuck high -> read drops after 8 stall cycles, then done, timeout=1, pass=0.
REQ-040 reset asserted in the second RD_TS stall cycle -> all outputs 0 immediately, no done; a subsequent start completes normally.
REQ-041 start pulsed during busy and coincident with done -> ignored, exactly one done per accepted start.
